crc8_serial: RTL and testbench

// - Bit-serial CRC-8 generator, one message bit per enabled clock, MSB of each byte first.
// - Sits beside the UART-style frame transmitter, which does the following:
//   - pulses reset during the start bit;
//   - asserts en while shifting framesize and frame payload bits into crcin;
//   - then sends crcout[7:0], MSB first, as the frame check byte.
// - Polynomial x^8+x^2+x+1 (0x07), init 0x00, no reflection, no final XOR (CRC-8/SMBUS).

---
 rtl/crc8_serial.sv | 32 +++
 tb/tb_crc8_serial.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 (default CRC-8/SMBUS: poly 0x07, init 0x00, no reflection, no final XOR).
// Absorbs one message bit per enabled clock, MSB first; crcout is the register itself.
module crc8_serial #(
  parameter logic [7:0] POLY = 8'h07,
  parameter logic [7:0] INIT = 8'h00
) (
  input  logic       en,
  input  logic       clk,
  input  logic       reset,
  input  logic       crcin,
  output logic [7:0] crcout
);

  logic       fb_c;
  logic [7:0] crc_next_c;

  // Feedback is the outgoing MSB folded with the incoming message bit
  always_comb begin
    fb_c       = crcout[7] ^ crcin;
    crc_next_c = {crcout[6:0], 1'b0} ^ (fb_c ? POLY : 8'h00);
  end

  // Reset wins over en; with en low the register holds
  always_ff @(posedge clk) begin
    if (reset) begin
      crcout <= INIT;
    end else if (en) begin
      crcout <= crc_next_c;
    end
  end

endmodule

// File: tb/tb_crc8_serial.sv
// Scoreboard bench for crc8_serial: stimulus pushes expected crcout per cycle,
// a monitor pops and compares just after each rising edge.
module tb_crc8_serial;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       crcin = 1'b0;
  logic [7:0] crcout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t sb[$];
  bit   msg[$];   // message bits absorbed since the last reset

  crc8_serial dut (
    .en    (en),
    .clk   (clk),
    .reset (reset),
    .crcin (crcin),
    .crcout(crcout)
  );

  always #5 clk = ~clk;

  // Reference: remainder of M(x)*x^8 divided by x^8+x^2+x+1, by long division
  function automatic logic [7:0] ref_crc();
    int rem = 0;
    int n   = msg.size();
    for (int i = 0; i < n + 8; i++) begin
      rem = (rem << 1) | ((i < n) ? int'(msg[i]) : 0);
      if ((rem & 32'h100) != 0) rem = rem ^ 32'h107;
    end
    return 8'(rem);
  endfunction

  // Drive one cycle; expected value is the model's unless a fixed value is given
  task automatic step(input logic r, input logic e, input logic b,
                      input bit use_fixed, input logic [7:0] fixed, input string nm);
    exp_t item;
    @(negedge clk);
    reset = r;
    en    = e;
    crcin = b;
    if (r) msg.delete();
    else if (e) msg.push_back(b);
    item.exp  = use_fixed ? fixed : ref_crc();
    item.name = nm;
    sb.push_back(item);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, "reset");
  endtask

  // Shift one byte MSB first; last bit optionally checked against a fixed value
  task automatic send_byte(input logic [7:0] b, input bit fix_last,
                           input logic [7:0] fixed, input string nm);
    for (int i = 7; i >= 0; i--)
      step(1'b0, 1'b1, b[i], (i == 0) && fix_last, fixed, nm);
  endtask

  // Monitor: compare one scoreboard entry per clock, away from the edge
  exp_t mon_item;
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_item = sb.pop_front();
      checks++;
      if (crcout !== mon_item.exp) begin
        errors++;
        $display("FAIL %s: crcout=%02h required=%02h at %0t",
                 mon_item.name, crcout, mon_item.exp, $time);
      end
    end
  end

  logic [7:0] trace80 [8];
  logic [7:0] str_b;
  logic [7:0] c;
  int         waited;

  initial begin
    trace80 = '{8'h07, 8'h0E, 8'h1C, 8'h38, 8'h70, 8'hE0, 8'hC7, 8'h89};

    // Reset dominance over en
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, "reset_dominance");

    // Byte 0x01, then a lone 1 bit from reset
    do_reset();
    send_byte(8'h01, 1'b1, 8'h07, "byte_01");
    do_reset();
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'h07, "single_bit_1");

    // Byte 0x80 with per-bit trace
    do_reset();
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b1, (i == 0), 1'b1, trace80[i], "byte_80_trace");

    // Check string "123456789"
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      str_b = 8'h30 + 8'(k);
      send_byte(str_b, k == 9, 8'hF4, "check_string");
    end

    // Hold with random crcin, then residue
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b1, 8'hF4, "hold");
    send_byte(8'hF4, 1'b1, 8'h00, "residue_check_string");

    // Reset mid-operation
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, "partial_ff");
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, "mid_reset");
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b1, (i == 0), i == 7, 8'h89, "after_mid_reset");

    // Random messages with idle gaps, occasional resets, then residue
    for (int m = 0; m < 25; m++) begin
      do_reset();
      for (int i = 0; i < int'($urandom_range(1, 48)); i++) begin
        if ($urandom_range(0, 3) == 0)
          step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 8'h00, "rand_idle");
        if ($urandom_range(0, 39) == 0)
          step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 8'h00, "rand_reset");
        step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 8'h00, "rand_bit");
      end
      c = ref_crc();
      send_byte(c, 1'b1, 8'h00, "rand_residue");
    end

    // Drain the scoreboard with a bounded wait
    @(negedge clk);
    en = 1'b0;
    waited = 0;
    while (sb.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
